// File: rtl/pulse_arb_pkg.sv
// Shared definitions for the pulse event arbiter.
// Contents:
//   MAX_REQ / IDX_W : largest supported requester count and its index width
//   arb_state_t     : arbiter FSM states
//   rr_pick_t       : result of a round-robin search (found flag + index)
//   rr_pick()       : rotating-priority search over a request vector
package pulse_arb_pkg;

   localparam int unsigned MAX_REQ = 8;
   localparam int unsigned IDX_W   = 3;
   localparam int unsigned TMO_W   = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_ACK  = 2'd1,
      WAIT_DONE = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } rr_pick_t;

   // Search req starting at ptr and wrapping at n; only the first n bits take part.
   // ptr is always below n, so a single conditional subtraction implements the wrap.
   function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                        input logic [IDX_W-1:0]   ptr,
                                        input int unsigned        n);
      rr_pick_t    res;
      int unsigned cand;
      res.found = 1'b0;
      res.idx   = {IDX_W{1'b0}};
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         cand = 32'(ptr) + k;
         if (cand >= n) begin
            cand = cand - n;
         end else begin
            cand = cand;
         end
         if ((k < n) && !res.found && req[cand[IDX_W-1:0]]) begin
            res.found = 1'b1;
            res.idx   = cand[IDX_W-1:0];
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/lvl_event_cap.sv
// Per-source level-to-event capture.
// A rising request level (arm flag clear) produces one event that sets the
// pending bit; the arm flag re-opens only after the level drops.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   lvl       : request level from the source
//   gnt_clr   : the arbiter is granting this source in the current cycle
//   clr_ovr   : clear the sticky overrun bit
//   pend      : registered pending-event flag
//   ovr       : registered sticky overrun flag
module lvl_event_cap (
   input  logic clk,
   input  logic rst,
   input  logic lvl,
   input  logic gnt_clr,
   input  logic clr_ovr,
   output logic pend,
   output logic ovr
);

   logic done;
   logic evt;

   assign evt = lvl & ~done;

   // Arm flag, pending bit and sticky overrun bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         done <= 1'b0;
         pend <= 1'b0;
         ovr  <= 1'b0;
      end else begin
         // done simply follows the level: set on an event, held while high, cleared when low.
         done <= lvl;
         // A fresh event beats a grant clear, so a re-request in the grant cycle stays pending.
         if (evt) begin
            pend <= 1'b1;
         end else if (gnt_clr) begin
            pend <= 1'b0;
         end else begin
            pend <= pend;
         end
         // Overrun setting beats clr_ovr so that a lost event is never hidden.
         if (evt && pend && !gnt_clr) begin
            ovr <= 1'b1;
         end else if (clr_ovr) begin
            ovr <= 1'b0;
         end else begin
            ovr <= ovr;
         end
      end
   end

endmodule

// File: rtl/pulse_event_arbiter.sv
// Round-robin arbiter that shares one single-shot command port among
// NUM_REQ level-signalling requesters. Each grant is a one-cycle pulse with
// the source index, after which the consumer must raise and then drop BUSY
// before the next grant; if BUSY never rises within ACK_TMO cycles a
// one-cycle TMO_ERR is reported and arbitration resumes.
// Ports:
//   CLK, RST   : clock, synchronous active-high reset
//   LVL_REQ    : per-source request levels
//   BUSY       : consumer busy level
//   CLR_OVR    : clears all OVERRUN bits
//   GNT_PULSE  : one-cycle grant strobe
//   GNT_ID     : granted index, holds its last value between grants
//   PEND       : pending-event flags
//   OVERRUN    : sticky per-source overrun flags
//   TMO_ERR    : one-cycle strobe when BUSY never rose after a grant
module pulse_event_arbiter
   import pulse_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ACK_TMO = 8
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [NUM_REQ-1:0]         LVL_REQ,
   input  logic                       BUSY,
   input  logic                       CLR_OVR,
   output logic                       GNT_PULSE,
   output logic [$clog2(NUM_REQ)-1:0] GNT_ID,
   output logic [NUM_REQ-1:0]         PEND,
   output logic [NUM_REQ-1:0]         OVERRUN,
   output logic                       TMO_ERR
);

   localparam int ID_W = $clog2(NUM_REQ);

   arb_state_t         state;
   logic [IDX_W-1:0]   ptr;
   logic [TMO_W-1:0]   cnt;
   logic               gnt_pulse;
   logic [ID_W-1:0]    gnt_id;
   logic               tmo_err;

   logic [MAX_REQ-1:0] req_ext;
   rr_pick_t           pick;
   logic               grant_now;
   logic [IDX_W-1:0]   ptr_next;
   logic [NUM_REQ-1:0] gnt_clr;
   logic [NUM_REQ-1:0] pend;
   logic [NUM_REQ-1:0] ovr;

   // Winner selection and the per-source grant clear for the deciding cycle.
   always_comb begin
      req_ext                 = {MAX_REQ{1'b0}};
      req_ext[NUM_REQ-1:0]    = pend;
      pick                    = rr_pick(req_ext, ptr, NUM_REQ);
      grant_now               = (state == IDLE) && !BUSY && pick.found;
      if (pick.idx == IDX_W'(NUM_REQ - 1)) begin
         ptr_next = {IDX_W{1'b0}};
      end else begin
         ptr_next = pick.idx + IDX_W'(1);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         gnt_clr[i] = grant_now && (pick.idx == IDX_W'(i));
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_cap
      lvl_event_cap u_cap (
         .clk     (CLK),
         .rst     (RST),
         .lvl     (LVL_REQ[g]),
         .gnt_clr (gnt_clr[g]),
         .clr_ovr (CLR_OVR),
         .pend    (pend[g]),
         .ovr     (ovr[g])
      );
   end

   // Arbiter FSM with round-robin pointer, ack timeout counter and output strobes.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         ptr       <= {IDX_W{1'b0}};
         cnt       <= {TMO_W{1'b0}};
         gnt_pulse <= 1'b0;
         gnt_id    <= {ID_W{1'b0}};
         tmo_err   <= 1'b0;
      end else begin
         gnt_pulse <= 1'b0;
         tmo_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_now) begin
                  gnt_pulse <= 1'b1;
                  gnt_id    <= pick.idx[ID_W-1:0];
                  ptr       <= ptr_next;
                  cnt       <= {TMO_W{1'b0}};
                  state     <= WAIT_ACK;
               end else begin
                  state <= IDLE;
               end
            end
            WAIT_ACK: begin
               // Counter is compared before incrementing, so TMO_ERR lands ACK_TMO+1 cycles after the grant.
               if (BUSY) begin
                  state <= WAIT_DONE;
               end else if (cnt == TMO_W'(ACK_TMO)) begin
                  tmo_err <= 1'b1;
                  state   <= IDLE;
               end else begin
                  cnt <= cnt + TMO_W'(1);
               end
            end
            WAIT_DONE: begin
               if (!BUSY) begin
                  state <= IDLE;
               end else begin
                  state <= WAIT_DONE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign GNT_PULSE = gnt_pulse;
   assign GNT_ID    = gnt_id;
   assign PEND      = pend;
   assign OVERRUN   = ovr;
   assign TMO_ERR   = tmo_err;

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Scoreboard bench for pulse_event_arbiter (NUM_REQ=4, ACK_TMO=8).
// Stimulus pushes expected grants (id + cycle) and timeout strobes into
// queues; a monitor pops and compares whenever GNT_PULSE or TMO_ERR is high.
module tb_pulse_event_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ACK_TMO = 8;

   typedef struct {
      int unsigned id;
      int unsigned at;
   } gnt_exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] lvl_req;
   logic       busy_man;
   logic       busy_auto;
   logic       busy;
   logic       clr_ovr;
   logic       gnt_pulse;
   logic [1:0] gnt_id;
   logic [3:0] pend;
   logic [3:0] overrun;
   logic       tmo_err;

   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          auto_busy = 1'b0;
   gnt_exp_t    gnt_q[$];
   int unsigned tmo_q[$];

   assign busy = busy_man | busy_auto;

   pulse_event_arbiter #(.NUM_REQ(NUM_REQ), .ACK_TMO(ACK_TMO)) dut (
      .CLK       (clk),
      .RST       (rst),
      .LVL_REQ   (lvl_req),
      .BUSY      (busy),
      .CLR_OVR   (clr_ovr),
      .GNT_PULSE (gnt_pulse),
      .GNT_ID    (gnt_id),
      .PEND      (pend),
      .OVERRUN   (overrun),
      .TMO_ERR   (tmo_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int unsigned t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic expect_gnt(input int unsigned id, input int unsigned at);
      gnt_exp_t e;
      e.id = id;
      e.at = at;
      gnt_q.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      lvl_req   = 4'b0000;
      busy_man  = 1'b0;
      clr_ovr   = 1'b0;
      auto_busy = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_gnt_pulse", 32'(gnt_pulse), 32'd0);
      check("rst_gnt_id", 32'(gnt_id), 32'd0);
      check("rst_pend", 32'(pend), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_tmo_err", 32'(tmo_err), 32'd0);
      rst = 1'b0;
   endtask

   // Monitor: every grant / timeout strobe is matched against the scoreboard.
   initial begin : monitor
      gnt_exp_t e;
      forever begin
         @(negedge clk);
         if (gnt_pulse === 1'b1) begin
            n_cmp++;
            if (gnt_q.size() == 0) begin
               n_bad++;
               $display("FAIL grant_unexpected: got id %0d at cycle %0d, expected no grant", gnt_id, cyc);
            end else begin
               e = gnt_q.pop_front();
               if (32'(gnt_id) !== e.id || cyc != e.at) begin
                  n_bad++;
                  $display("FAIL grant: got id %0d at cycle %0d, expected id %0d at cycle %0d",
                           gnt_id, cyc, e.id, e.at);
               end
            end
         end
         if (tmo_err === 1'b1) begin
            n_cmp++;
            if (tmo_q.size() == 0) begin
               n_bad++;
               $display("FAIL tmo_unexpected: got TMO_ERR at cycle %0d, expected none", cyc);
            end else begin
               int unsigned t;
               t = tmo_q.pop_front();
               if (cyc != t) begin
                  n_bad++;
                  $display("FAIL tmo_cycle: got TMO_ERR at cycle %0d, expected cycle %0d", cyc, t);
               end
            end
         end
      end
   end

   // Consumer model: after each grant hold BUSY high for two cycles.
   initial begin : responder
      busy_auto = 1'b0;
      forever begin
         @(negedge clk);
         if (auto_busy && gnt_pulse === 1'b1) begin
            busy_auto = 1'b1;
            repeat (2) @(negedge clk);
            busy_auto = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not end, expected finish");
      $fatal(1);
   end

   initial begin : stimulus
      int unsigned c;
      rst      = 1'b1;
      lvl_req  = 4'b0000;
      busy_man = 1'b0;
      clr_ovr  = 1'b0;

      // 1) Level held high: one grant only, BUSY stays low so a timeout follows.
      do_reset();
      c = cyc;
      lvl_req = 4'b0001;
      expect_gnt(0, c + 2);
      tmo_q.push_back(c + 11);
      wait_cyc(c + 1);  check("s1_pend_set", 32'(pend), 32'h1);
      wait_cyc(c + 2);  check("s1_pend_clr", 32'(pend), 32'h0);
      wait_cyc(c + 16); check("s1_pend_hold", 32'(pend), 32'h0);
      lvl_req = 4'b0000;
      wait_cyc(c + 18);

      // 2) All four at once, consumer handshakes: grants 0,1,2,3.
      do_reset();
      c = cyc;
      auto_busy = 1'b1;
      lvl_req = 4'b1111;
      expect_gnt(0, c + 2);
      expect_gnt(1, c + 6);
      expect_gnt(2, c + 10);
      expect_gnt(3, c + 14);
      wait_cyc(c + 1);  check("s2_pend_1111", 32'(pend), 32'hF);
      wait_cyc(c + 2);  check("s2_pend_1110", 32'(pend), 32'hE);
      wait_cyc(c + 6);  check("s2_pend_1100", 32'(pend), 32'hC);
      wait_cyc(c + 10); check("s2_pend_1000", 32'(pend), 32'h8);
      wait_cyc(c + 14); check("s2_pend_0000", 32'(pend), 32'h0);
      lvl_req = 4'b0000;
      wait_cyc(c + 18);

      // 3) Overrun on source 2 while held in WAIT_DONE; set beats clear; then clear.
      do_reset();
      c = cyc;
      lvl_req = 4'b0001;
      expect_gnt(0, c + 2);
      wait_cyc(c + 2);  busy_man = 1'b1;
      wait_cyc(c + 3);  lvl_req = 4'b0100;
      wait_cyc(c + 4);  check("s3_pend_src2", 32'(pend), 32'h4); lvl_req = 4'b0000;
      wait_cyc(c + 5);  lvl_req = 4'b0100;
      wait_cyc(c + 6);  check("s3_overrun_set", 32'(overrun), 32'h4); lvl_req = 4'b0000;
      wait_cyc(c + 7);  lvl_req = 4'b0100; clr_ovr = 1'b1;
      wait_cyc(c + 8);  check("s3_overrun_set_wins", 32'(overrun), 32'h4);
      wait_cyc(c + 9);  check("s3_overrun_cleared", 32'(overrun), 32'h0);
      clr_ovr = 1'b0; busy_man = 1'b0; auto_busy = 1'b1;
      expect_gnt(2, c + 11);
      wait_cyc(c + 11); check("s3_pend_after_gnt", 32'(pend), 32'h0);
      wait_cyc(c + 13); check("s3_gnt_id_holds", 32'(gnt_id), 32'd2);
      lvl_req = 4'b0000;
      wait_cyc(c + 16);

      // 4) Timeout: BUSY never rises; next pending source granted right after TMO_ERR.
      do_reset();
      c = cyc;
      lvl_req = 4'b0011;
      expect_gnt(0, c + 2);
      tmo_q.push_back(c + 11);
      expect_gnt(1, c + 12);
      wait_cyc(c + 1);  check("s4_pend_0011", 32'(pend), 32'h3);
      wait_cyc(c + 2);  check("s4_pend_0010", 32'(pend), 32'h2);
      wait_cyc(c + 11); auto_busy = 1'b1;
      wait_cyc(c + 12); check("s4_pend_0000", 32'(pend), 32'h0); lvl_req = 4'b0000;
      wait_cyc(c + 18);

      // 5) Source 1 re-requests in the very cycle its pending bit is granted.
      do_reset();
      c = cyc;
      lvl_req = 4'b0010;
      busy_man = 1'b1;
      wait_cyc(c + 1);  check("s5_pend_src1", 32'(pend), 32'h2); lvl_req = 4'b0000;
      wait_cyc(c + 2);  lvl_req = 4'b0010; busy_man = 1'b0; auto_busy = 1'b1;
      expect_gnt(1, c + 3);
      expect_gnt(1, c + 7);
      wait_cyc(c + 3);  check("s5_pend_kept", 32'(pend), 32'h2);
      check("s5_no_overrun", 32'(overrun), 32'h0);
      wait_cyc(c + 7);  check("s5_pend_done", 32'(pend), 32'h0); lvl_req = 4'b0000;
      wait_cyc(c + 12);

      // 6) Reset in WAIT_DONE with PEND=1010 discards everything.
      do_reset();
      c = cyc;
      lvl_req = 4'b0001;
      expect_gnt(0, c + 2);
      wait_cyc(c + 2);  busy_man = 1'b1; lvl_req = 4'b1010;
      wait_cyc(c + 3);  check("s6_pend_1010", 32'(pend), 32'hA);
      rst = 1'b1; lvl_req = 4'b0000;
      wait_cyc(c + 4);
      check("s6_gnt_pulse", 32'(gnt_pulse), 32'd0);
      check("s6_gnt_id", 32'(gnt_id), 32'd0);
      check("s6_pend", 32'(pend), 32'd0);
      check("s6_overrun", 32'(overrun), 32'd0);
      check("s6_tmo_err", 32'(tmo_err), 32'd0);
      rst = 1'b0; busy_man = 1'b0;
      wait_cyc(c + 12); check("s6_pend_idle", 32'(pend), 32'd0);

      check("grants_outstanding", 32'(gnt_q.size()), 32'd0);
      check("tmo_outstanding", 32'(tmo_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pulse_event_arbiter.md
# pulse_event_arbiter

Round-robin scheduler sharing one single-shot command port among NUM_REQ level-signalling requesters in the system-control clock domain. Each requester level is reduced to one event per assertion (re-armed only after deassertion). Pending events are granted one at a time as a one-cycle grant pulse with source ID. Each grant is followed by a busy handshake from the shared consumer before the next grant is issued.

## Interface
- NUM_REQ, 4, number of requesters (2..8); ID_W = clog2(NUM_REQ) derived locally
- ACK_TMO, 8, cycles allowed after a grant for BUSY to rise (1..255)
- CLK  in  1  block clock
- RST  in  1  reset, synchronous, active-high
- LVL_REQ  in  NUM_REQ  per-source request level, CLK-synchronous
- BUSY  in  1  consumer busy level
- CLR_OVR  in  1  clears all OVERRUN bits
- GNT_PULSE  out  1  one-cycle grant strobe
- GNT_ID  out  ID_W  granted source index, valid while GNT_PULSE=1, holds last value otherwise
- PEND  out  NUM_REQ  pending-event flags
- OVERRUN  out  NUM_REQ  sticky: event arrived while same source already pending
- TMO_ERR  out  1  one-cycle strobe: BUSY never rose after a grant

## Operation
- Reset values: GNT_PULSE=0, GNT_ID=0, PEND=0, OVERRUN=0, TMO_ERR=0, all arm flags cleared, RR pointer=0, state IDLE, timeout counter=0.
- Per-source capture uses arm flag `done[i]`:
  - LVL_REQ[i]=1 and done[i]=0: set PEND[i] and done[i].
  - LVL_REQ[i]=0: clear done[i].
  - LVL_REQ[i] held high out of reset produces exactly one event.
- Overrun: a new event on source i while PEND[i]=1 and not being granted that cycle sets OVERRUN[i].
- OVERRUN is cleared only by CLR_OVR. If CLR_OVR and a new overrun occur in the same cycle, set wins.
- State machine:
  - IDLE: if PEND≠0 and BUSY=0, pick the first set PEND bit searching from pointer upward, wrapping. Next cycle: GNT_PULSE=1, GNT_ID=winner, PEND[winner] cleared, pointer=(winner+1) mod NUM_REQ, counter=0, go to WAIT_ACK.
  - WAIT_ACK: if BUSY=1, go to WAIT_DONE. Otherwise increment counter; when counter reaches ACK_TMO, assert TMO_ERR for one cycle and go to IDLE.
  - WAIT_DONE: when BUSY=0, go to IDLE. There is no timeout in this state.
- Simultaneous event on source i in the same cycle PEND[i] is cleared by a grant: PEND[i] stays 1, no overrun.
- While not IDLE, events still accumulate in PEND. No grant is issued until the state returns to IDLE.
- RST asserted in any state: next cycle equals reset values; pending events and overrun flags are discarded.

## Timing
- All outputs are registered.
- LVL_REQ rise sampled at edge k: PEND visible after edge k.
- GNT_PULSE high after edge k+1 if IDLE and BUSY=0, so minimum latency is 2 cycles.
- Back-to-back grants: minimum 3 cycles apart (grant, WAIT_ACK sees BUSY, WAIT_DONE sees BUSY low, IDLE decides).
- TMO_ERR occurs ACK_TMO+1 cycles after GNT_PULSE when BUSY stays low.
- Next grant is possible 1 cycle after TMO_ERR.

## Structure
- Package `pulse_arb_pkg`:
  - state enum (IDLE, WAIT_ACK, WAIT_DONE)
  - max NUM_REQ constant
  - rotate-priority function returning winner index and found flag
- Sub-module `lvl_event_cap`: one per source (generate loop). Holds the arm flag, pending bit and overrun bit; inputs are level, grant-clear and clr_ovr.
- Top level: FSM, RR pointer, timeout counter, output registers.

## Test plan
- Reset, then LVL_REQ=4'b0001 held high for 10 cycles with BUSY=0 -> single GNT_PULSE with GNT_ID=0 two cycles after the rise; no second grant while the level stays high.
- LVL_REQ=4'b1111 in one cycle, BUSY pulsed high for 2 cycles after each grant -> grants in order ID 0,1,2,3; PEND goes 1111→1110→1100→1000→0000.
- Source 2 pulsed twice (low between) while its first event is still pending because BUSY holds WAIT_DONE -> OVERRUN=4'b0100; it clears one cycle after CLR_OVR=1.
- Grant with BUSY kept 0 -> TMO_ERR high exactly 9 cycles after GNT_PULSE (ACK_TMO=8), state back to IDLE; the next pending source is granted on the following cycle.
- Source 1 rises in the same cycle its pending is cleared by a grant -> PEND[1]=1 afterwards, OVERRUN[1]=0, second grant to ID 1 follows.
- RST asserted during WAIT_DONE with PEND=4'b1010 -> next cycle all outputs zero; no grant after RST drops until new level edges.
